// File: rtl/raster_pkg.sv
// Shared definitions for the object raster scheduler: FSM state encoding and
// default geometry widths.
package raster_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEEK = 2'd1,
      SCAN = 2'd2,
      DONE = 2'd3
   } state_e;

   localparam int DEF_NUM_OBJ = 8;
   localparam int DEF_XW      = 8;
   localparam int DEF_YW      = 7;
   localparam int DEF_SW      = 5;
   localparam int DEF_CW      = 3;

endpackage

// File: rtl/rect_raster_counter.sv
// Row-major column/row walker over a w x h rectangle. 'last' flags the final
// pixel (w-1, h-1); 'clear' restarts at (0,0) and wins over 'advance'.
module rect_raster_counter
   import raster_pkg::*;
#(
   parameter int SW = DEF_SW
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [SW-1:0] w,
   input  logic [SW-1:0] h,
   input  logic          advance,
   input  logic          clear,
   output logic [SW-1:0] col,
   output logic [SW-1:0] row,
   output logic          last
);

   logic [SW-1:0] col_q, col_d;
   logic [SW-1:0] row_q, row_d;
   logic          last_col;

   assign last_col = (col_q == w - SW'(1));
   assign last     = last_col && (row_q == h - SW'(1));
   assign col      = col_q;
   assign row      = row_q;

   // Next position: restart on clear, otherwise step col and wrap into the next row.
   always_comb begin
      col_d = col_q;
      row_d = row_q;
      if (clear) begin
         col_d = '0;
         row_d = '0;
      end else if (advance) begin
         if (last_col) begin
            col_d = '0;
            row_d = row_q + SW'(1);
         end else begin
            col_d = col_q + SW'(1);
         end
      end
   end

   // Position registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_q <= '0;
         row_q <= '0;
      end else begin
         col_q <= col_d;
         row_q <= row_d;
      end
   end

endmodule

// File: rtl/object_raster_scheduler.sv
// Walks a snapshot of up to NUM_OBJ rectangles and emits their pixels one per
// handshake in row-major order, object by object, then pulses frame_done.
// Optional macro OBJECT_RASTER_CLIP_EN drops pixels beyond X_MAX/Y_MAX (one
// idle cycle each); without it coordinates wrap at the port widths.
module object_raster_scheduler
   import raster_pkg::*;
#(
   parameter int NUM_OBJ = DEF_NUM_OBJ,
   parameter int XW      = DEF_XW,
   parameter int YW      = DEF_YW,
   parameter int SW      = DEF_SW,
`ifdef OBJECT_RASTER_CLIP_EN
   parameter int CW      = DEF_CW,
   parameter int X_MAX   = 160,
   parameter int Y_MAX   = 120
`else
   parameter int CW      = DEF_CW
`endif
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [NUM_OBJ*XW-1:0] obj_x,
   input  logic [NUM_OBJ*YW-1:0] obj_y,
   input  logic [NUM_OBJ*SW-1:0] obj_w,
   input  logic [NUM_OBJ*SW-1:0] obj_h,
   input  logic [NUM_OBJ*CW-1:0] obj_c,
   input  logic [NUM_OBJ-1:0]    obj_en,
   output logic [XW-1:0]         pix_x,
   output logic [YW-1:0]         pix_y,
   output logic [CW-1:0]         pix_c,
   output logic                  pix_valid,
   input  logic                  pix_ready,
   output logic                  busy,
   output logic                  frame_done
);

   localparam int IW = $clog2(NUM_OBJ + 1);
`ifdef OBJECT_RASTER_CLIP_EN
   // One spare bit keeps x+col / y+row untruncated for the clip compare.
   localparam int CXW = ((XW > SW) ? XW : SW) + 1;
   localparam int CYW = ((YW > SW) ? YW : SW) + 1;
`else
   localparam int CXW = XW;
   localparam int CYW = YW;
`endif

   state_e                  state_q, state_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [NUM_OBJ*XW-1:0]   sh_x_q, sh_x_d;
   logic [NUM_OBJ*YW-1:0]   sh_y_q, sh_y_d;
   logic [NUM_OBJ*SW-1:0]   sh_w_q, sh_w_d;
   logic [NUM_OBJ*SW-1:0]   sh_h_q, sh_h_d;
   logic [NUM_OBJ*CW-1:0]   sh_c_q, sh_c_d;
   logic [NUM_OBJ-1:0]      sh_en_q, sh_en_d;
   logic [CXW-1:0]          cur_x_q, cur_x_d;
   logic [CYW-1:0]          cur_y_q, cur_y_d;
   logic [CW-1:0]           pix_c_q, pix_c_d;
   logic                    pix_valid_q, pix_valid_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;

   logic [XW-1:0]           o_x;
   logic [YW-1:0]           o_y;
   logic [SW-1:0]           o_w, o_h;
   logic [CW-1:0]           o_c;
   logic                    o_en;
   logic [SW-1:0]           cnt_col, cnt_row;
   logic                    cnt_last, cnt_adv, cnt_clr, adv;

`ifdef OBJECT_RASTER_CLIP_EN
   function automatic logic visible(input logic [CXW-1:0] x, input logic [CYW-1:0] y);
      return (int'(x) < X_MAX) && (int'(y) < Y_MAX);
   endfunction
`else
   function automatic logic visible(input logic [CXW-1:0] x, input logic [CYW-1:0] y);
      return (x == x) && (y == y);
   endfunction
`endif

   assign pix_x      = cur_x_q[XW-1:0];
   assign pix_y      = cur_y_q[YW-1:0];
   assign pix_c      = pix_c_q;
   assign pix_valid  = pix_valid_q;
   assign busy       = busy_q;
   assign frame_done = done_q;

   rect_raster_counter #(.SW(SW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .w       (o_w),
      .h       (o_h),
      .advance (cnt_adv),
      .clear   (cnt_clr),
      .col     (cnt_col),
      .row     (cnt_row),
      .last    (cnt_last)
   );

   // Pick the shadow fields of the object under idx (zero once idx == NUM_OBJ).
   always_comb begin
      o_x  = '0;
      o_y  = '0;
      o_w  = '0;
      o_h  = '0;
      o_c  = '0;
      o_en = 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (idx_q == IW'(i)) begin
            o_x  = sh_x_q[i*XW +: XW];
            o_y  = sh_y_q[i*YW +: YW];
            o_w  = sh_w_q[i*SW +: SW];
            o_h  = sh_h_q[i*SW +: SW];
            o_c  = sh_c_q[i*CW +: CW];
            o_en = sh_en_q[i];
         end
      end
   end

   // A SCAN position retires on handshake; a clipped one retires unconditionally.
`ifdef OBJECT_RASTER_CLIP_EN
   assign adv = (pix_valid_q && pix_ready) || !pix_valid_q;
`else
   assign adv = pix_valid_q && pix_ready;
`endif

   // Frame sequencing: snapshot, seek next drawable object, scan it, finish.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      sh_x_d      = sh_x_q;
      sh_y_d      = sh_y_q;
      sh_w_d      = sh_w_q;
      sh_h_d      = sh_h_q;
      sh_c_d      = sh_c_q;
      sh_en_d     = sh_en_q;
      cur_x_d     = cur_x_q;
      cur_y_d     = cur_y_q;
      pix_c_d     = pix_c_q;
      pix_valid_d = pix_valid_q;
      cnt_adv     = 1'b0;
      cnt_clr     = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               sh_x_d  = obj_x;
               sh_y_d  = obj_y;
               sh_w_d  = obj_w;
               sh_h_d  = obj_h;
               sh_c_d  = obj_c;
               sh_en_d = obj_en;
               idx_d   = '0;
               state_d = SEEK;
            end
         end
         SEEK: begin
            if (idx_q == IW'(NUM_OBJ)) begin
               state_d = DONE;
            end else if (o_en && (o_w != '0) && (o_h != '0)) begin
               state_d     = SCAN;
               cnt_clr     = 1'b1;
               cur_x_d     = CXW'(o_x);
               cur_y_d     = CYW'(o_y);
               pix_c_d     = o_c;
               pix_valid_d = visible(CXW'(o_x), CYW'(o_y));
            end else begin
               // Skipping the final object goes straight to DONE.
               idx_d = idx_q + IW'(1);
               if (idx_q == IW'(NUM_OBJ - 1))
                  state_d = DONE;
            end
         end
         SCAN: begin
            if (adv) begin
               if (cnt_last) begin
                  idx_d       = idx_q + IW'(1);
                  state_d     = SEEK;
                  pix_valid_d = 1'b0;
               end else begin
                  cnt_adv = 1'b1;
                  if (cnt_col == o_w - SW'(1)) begin
                     cur_x_d = CXW'(o_x);
                     cur_y_d = CYW'(o_y) + CYW'(cnt_row) + CYW'(1);
                  end else begin
                     cur_x_d = cur_x_q + CXW'(1);
                  end
                  pix_valid_d = visible(cur_x_d, cur_y_d);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   // State, shadow and registered output flops.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         sh_x_q      <= '0;
         sh_y_q      <= '0;
         sh_w_q      <= '0;
         sh_h_q      <= '0;
         sh_c_q      <= '0;
         sh_en_q     <= '0;
         cur_x_q     <= '0;
         cur_y_q     <= '0;
         pix_c_q     <= '0;
         pix_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         sh_x_q      <= sh_x_d;
         sh_y_q      <= sh_y_d;
         sh_w_q      <= sh_w_d;
         sh_h_q      <= sh_h_d;
         sh_c_q      <= sh_c_d;
         sh_en_q     <= sh_en_d;
         cur_x_q     <= cur_x_d;
         cur_y_q     <= cur_y_d;
         pix_c_q     <= pix_c_d;
         pix_valid_q <= pix_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

endmodule
